morse_encoder_param: RTL
========================

Name: morse_encoder_param

Overview:
Parametrised Morse code encoder. It accepts a one-cycle letter load (A–Z), looks up the pattern in an internal ROM, and drives a single light output with dot, dash, intra-letter gap and inter-letter gap timing. All timing is derived from a configurable unit-tick divider. It generalises the Lab 7 Part 4 letter FSM: full alphabet, programmable unit and dash/gap lengths, busy/done handshake, and invalid-letter error. It sits between the switch/key debouncing and the LEDR light.

Parameters:
TICK_DIV, 25000000, clk cycles per Morse time unit (0.5 s at 50 MHz); must be >= 2.
DASH_UNITS, 3, dash length in units; must be >= 2.
GAP_UNITS, 1, intra-letter off time between symbols, in units; must be >= 1.
TAIL_UNITS, 3, off time after the last symbol before done, in units; must be >= 1.
LTR_W, 5, letter index width; 0 = A … 25 = Z.

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
ld_ltr  in  1  load strobe; sampled on rising clk edge
in_ltr  in  LTR_W  letter index, valid when ld_ltr = 1
light_on  out  1  Morse light; high during a mark
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle pulse at end of letter
err  out  1  one-cycle pulse when ld_ltr carries in_ltr > 25
curr_state  out  3  state encoding, for debug and LEDs

Behaviour:
- Reset (async, reset_n = 0) clears everything immediately: state IDLE, light_on/busy/done/err = 0, curr_state = 0, tick and unit counters = 0, and the shift/length registers = 0. This applies mid-letter too.
- States and curr_state encoding: IDLE = 0, MARK = 1, GAP = 2, TAIL = 3, DONE = 4. Encodings 5–7 are unreachable and recover to IDLE.
- ROM: combinational lookup giving len[2:0] (1–4) and pat[3:0]. The pattern is LSB-first: bit 0 is the first symbol, 1 = dash, 0 = dot. All A–Z codes use standard International Morse.
- IDLE, ld_ltr = 1, in_ltr <= 25: latch pat into a shift register and len into a remaining-symbol count, clear the counters, go to MARK.
- IDLE, ld_ltr = 1, in_ltr > 25: err = 1 for the next cycle and stay in IDLE.
- ld_ltr in any state other than IDLE is ignored. No queueing.
- Outputs decode from the state register only:
  - light_on = (state == MARK)
  - busy = MARK, GAP or TAIL
  - done = (state == DONE)
- Latency: with ld_ltr sampled at edge k, light_on is high starting in cycle k+1.
- Tick counter: counts 0..TICK_DIV-1 and produces a unit tick on the terminal count. It is cleared on every state entry, so every interval is an exact multiple of TICK_DIV cycles. It never free-runs across intervals.
- MARK lasts 1 unit if the current pattern bit is 0, or DASH_UNITS units if it is 1. On expiry, the pattern shifts right and the remaining count decrements. Then:
  - remaining count still > 0 → GAP
  - otherwise → TAIL
- GAP lasts GAP_UNITS units, then returns to MARK.
- TAIL lasts TAIL_UNITS units, then goes to DONE.
- DONE lasts one cycle (done = 1), then IDLE. A new ld_ltr is accepted from IDLE, i.e. the earliest is the cycle after done.
- Unit counter width is clog2(max(DASH_UNITS, GAP_UNITS, TAIL_UNITS) + 1).
- Tick counter width is clog2(TICK_DIV).

Decomposition:
- Shared header morse_defs.vh holds:
  - state encoding constants
  - letter index constants (LTR_A … LTR_Z)
  - the ROM contents as a function returning {len, pat}, shared with the bench's reference model
- One sub-module, unit_tick_gen: the parametrised successor of half_sec_counter.
  - Ports: clk, reset_n, clr, tick.
  - Parameter: TICK_DIV.

Test Plan (TICK_DIV = 4, others default, clk 20 ns):
- 'A' (0, .-), ld_ltr at edge 0 → light_on high cycles 1–4, low 5–8, high 9–20, low 21–32; done pulse in cycle 33; busy high cycles 1–32.
- 'E' (4, .) → light_on high 4 cycles, low 12 cycles, then done; 'T' (19, -) → light_on high 12 cycles, low 12 cycles, then done.
- 'H' (7, ....) → four 4-cycle marks separated by three 4-cycle gaps, then a 12-cycle tail and done.
  - Repeat with ld_ltr pulsed for 'A' in cycle 6 (mid-letter) → the pulse is ignored and the waveform is identical.
- in_ltr = 26 and in_ltr = 31 with ld_ltr → err high for exactly one cycle; busy and light_on stay 0; curr_state stays 0.
- Start 'O' (14, ---) and assert reset_n = 0 in cycle 5 (mid-MARK) → light_on/busy drop immediately, without waiting for a clock edge. After release, a load of 'E' produces the correct 'E' timing.
- Back-to-back letters: 'S' then ld_ltr 'O' in the cycle right after done → 'O' is accepted, and light_on rises in the next cycle.

Source files
------------

// File: rtl/morse_encoder_param_pkg.sv
// Shared Morse definitions: FSM state encoding, letter indices and the letter ROM.
package morse_encoder_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MARK = 3'd1,
        ST_GAP  = 3'd2,
        ST_TAIL = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int LTR_A = 0,  LTR_B = 1,  LTR_C = 2,  LTR_D = 3,  LTR_E = 4,  LTR_F = 5;
    localparam int LTR_G = 6,  LTR_H = 7,  LTR_I = 8,  LTR_J = 9,  LTR_K = 10, LTR_L = 11;
    localparam int LTR_M = 12, LTR_N = 13, LTR_O = 14, LTR_P = 15, LTR_Q = 16, LTR_R = 17;
    localparam int LTR_S = 18, LTR_T = 19, LTR_U = 20, LTR_V = 21, LTR_W = 22, LTR_X = 23;
    localparam int LTR_Y = 24, LTR_Z = 25;

    // pat is LSB-first: bit 0 is the first symbol, 1 = dash, 0 = dot
    typedef struct packed {
        logic [2:0] len;
        logic [3:0] pat;
    } code_t;

    function automatic code_t morse_rom(input int unsigned idx);
        code_t c;
        c = '{len: 3'd0, pat: 4'b0000};
        case (idx)
            LTR_A: c = '{len: 3'd2, pat: 4'b0010};
            LTR_B: c = '{len: 3'd4, pat: 4'b0001};
            LTR_C: c = '{len: 3'd4, pat: 4'b0101};
            LTR_D: c = '{len: 3'd3, pat: 4'b0001};
            LTR_E: c = '{len: 3'd1, pat: 4'b0000};
            LTR_F: c = '{len: 3'd4, pat: 4'b0100};
            LTR_G: c = '{len: 3'd3, pat: 4'b0011};
            LTR_H: c = '{len: 3'd4, pat: 4'b0000};
            LTR_I: c = '{len: 3'd2, pat: 4'b0000};
            LTR_J: c = '{len: 3'd4, pat: 4'b1110};
            LTR_K: c = '{len: 3'd3, pat: 4'b0101};
            LTR_L: c = '{len: 3'd4, pat: 4'b0010};
            LTR_M: c = '{len: 3'd2, pat: 4'b0011};
            LTR_N: c = '{len: 3'd2, pat: 4'b0001};
            LTR_O: c = '{len: 3'd3, pat: 4'b0111};
            LTR_P: c = '{len: 3'd4, pat: 4'b0110};
            LTR_Q: c = '{len: 3'd4, pat: 4'b1011};
            LTR_R: c = '{len: 3'd3, pat: 4'b0010};
            LTR_S: c = '{len: 3'd3, pat: 4'b0000};
            LTR_T: c = '{len: 3'd1, pat: 4'b0001};
            LTR_U: c = '{len: 3'd3, pat: 4'b0100};
            LTR_V: c = '{len: 3'd4, pat: 4'b1000};
            LTR_W: c = '{len: 3'd3, pat: 4'b0110};
            LTR_X: c = '{len: 3'd4, pat: 4'b1001};
            LTR_Y: c = '{len: 3'd4, pat: 4'b1101};
            LTR_Z: c = '{len: 3'd4, pat: 4'b0011};
            default: c = '{len: 3'd0, pat: 4'b0000};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/morse_encoder_param_unit_tick.sv
// Unit-tick divider: pulses tick on the last of every TICK_DIV cycles.
// Latency: tick is combinational from the count register.
// Backpressure: none; clr restarts the interval so each one is an exact multiple of TICK_DIV.
module unit_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/morse_encoder_param.sv
// Morse letter encoder: A-Z load drives timed marks/gaps on light_on, then a done pulse.
// Latency: light_on rises the cycle after a load is accepted; err pulses the cycle after a bad load.
// Backpressure: loads are taken only in IDLE; any ld_ltr while busy or done is dropped.
module morse_encoder_param
    import morse_encoder_param_pkg::*;
#(
    parameter int TICK_DIV   = 25000000,
    parameter int DASH_UNITS = 3,
    parameter int GAP_UNITS  = 1,
    parameter int TAIL_UNITS = 3,
    parameter int LTR_W      = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ld_ltr,
    input  logic [LTR_W-1:0] in_ltr,
    output logic             light_on,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       curr_state
);

    localparam int MAX_DG = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
    localparam int MAX_U  = (MAX_DG > TAIL_UNITS) ? MAX_DG : TAIL_UNITS;
    localparam int UNIT_W = $clog2(MAX_U + 1);
    localparam logic [LTR_W-1:0] LAST_LTR = LTR_W'(LTR_Z);

    state_t            state, state_nxt;
    logic [3:0]        shift_pat;
    logic [2:0]        rem_len;
    logic [UNIT_W-1:0] unit_cnt;
    logic [UNIT_W-1:0] ivl_units;
    logic              tick, clr, ivl_end;
    logic              accept, bad_ltr, err_q;
    code_t             code;

    assign code = morse_rom(32'(in_ltr));

    unit_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .tick    (tick)
    );

    always_comb begin
        ivl_units = UNIT_W'(1);
        case (state)
            ST_MARK: ivl_units = shift_pat[0] ? UNIT_W'(DASH_UNITS) : UNIT_W'(1);
            ST_GAP:  ivl_units = UNIT_W'(GAP_UNITS);
            ST_TAIL: ivl_units = UNIT_W'(TAIL_UNITS);
            default: ivl_units = UNIT_W'(1);
        endcase
    end

    assign ivl_end = tick && (unit_cnt == ivl_units - 1'b1);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        bad_ltr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ld_ltr) begin
                    if (in_ltr <= LAST_LTR) begin
                        accept    = 1'b1;
                        state_nxt = ST_MARK;
                    end else begin
                        bad_ltr = 1'b1;
                    end
                end
            end
            // rem_len still counts the symbol just finished
            ST_MARK: if (ivl_end) state_nxt = (rem_len > 3'd1) ? ST_GAP : ST_TAIL;
            ST_GAP:  if (ivl_end) state_nxt = ST_MARK;
            ST_TAIL: if (ivl_end) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // every state entry restarts both the tick and unit counters
    assign clr = (state_nxt != state) || (state == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            shift_pat <= '0;
            rem_len   <= '0;
            unit_cnt  <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= bad_ltr;
            if (accept) begin
                shift_pat <= code.pat;
                rem_len   <= code.len;
            end else if (state == ST_MARK && ivl_end) begin
                shift_pat <= shift_pat >> 1;
                rem_len   <= rem_len - 1'b1;
            end
            if (clr) begin
                unit_cnt <= '0;
            end else if (tick) begin
                unit_cnt <= unit_cnt + 1'b1;
            end
        end
    end

    assign light_on   = (state == ST_MARK);
    assign busy       = (state == ST_MARK) || (state == ST_GAP) || (state == ST_TAIL);
    assign done       = (state == ST_DONE);
    assign err        = err_q;
    assign curr_state = state;

endmodule
